ssd_capture: RTL and testbench

SSD_CAPTURE -- requirements
Module: ssd_capture

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/ssd_seg_decode.sv | 23 ++
 rtl/ssd_capture.sv | 216 +++++++++++++++++++++
 tb/tb_ssd_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment display capture block.
// Holds the capture FSM state type, the active-low glyph table ({a,b,c,d,e,f,g},
// indexed by hex value) and the blank pattern used as the reset value.
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Element [i] is the active-low pattern of hex digit i.
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: combinational glyph decoder. Maps a raw active-low segment
// pattern to its hex value; unknown patterns (including blank) give hex 0, ok 0.
module ssd_seg_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] hex_o,
   output logic       ok_o
);

   // Search the glyph table for an exact match.
   always_comb begin
      hex_o = 4'd0;
      ok_o  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == GLYPH_TBL[i]) begin
            hex_o = 4'(i);
            ok_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: recovers the four digits shown on a multiplexed, active-low
// seven-segment display. Each digit is captured once its segment and anode lines
// have been stable for STABLE_CNT sampled cycles; frame_valid pulses when all four
// digits have been seen.
// Optional feature: define SSD_CAPTURE_TIMEOUT_EN to add the scan-stall watchdog
// (stall sets after TIMEOUT cycles without a capture); otherwise stall is tied 0.
module ssd_capture
   import ssd_pkg::*;
#(
   parameter int STABLE_CNT = 8,
   parameter int TIMEOUT    = 131072
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   input  logic       an0,
   input  logic       an1,
   input  logic       an2,
   input  logic       an3,
   output logic [6:0] seg0,
   output logic [6:0] seg1,
   output logic [6:0] seg2,
   output logic [6:0] seg3,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] dig_ok,
   output logic       frame_valid,
   output logic       stall
);

   localparam int             CW       = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);

   if (STABLE_CNT < 1 || TIMEOUT < 1) begin : g_param_check
      $error("ssd_capture: STABLE_CNT and TIMEOUT must be at least 1");
   end

   logic [6:0]    seg_s_q;
   logic [3:0]    an_s_q;     // {an3, an2, an1, an0}
   logic [10:0]   prev_q;
   logic          same;
   logic          an_valid;
   logic [1:0]    dig;
   logic [3:0]    dig_hot;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          capture;
   logic [3:0]    dec_hex;
   logic          dec_ok;
   logic [6:0]    seg_q [4];
   logic [3:0]    hex_q [4];
   logic [3:0]    ok_q;
   logic [3:0]    seen_q;
   logic          fv_q;
   logic          to_hit;

   // Sample stage: register the raw pins once, and keep the previous sample for change detection.
   always_ff @(posedge clk) begin
      seg_s_q <= {a, b, c, d, e, f, g};
      an_s_q  <= {an3, an2, an1, an0};
      prev_q  <= {seg_s_q, an_s_q};
   end

   assign same = ({seg_s_q, an_s_q} == prev_q);

   // Anode decode: exactly one low line selects a digit (an3 is the leftmost physical digit0).
   always_comb begin
      an_valid = 1'b0;
      dig      = 2'd0;
      case (an_s_q)
         4'b0111: begin an_valid = 1'b1; dig = 2'd0; end
         4'b1110: begin an_valid = 1'b1; dig = 2'd1; end
         4'b1101: begin an_valid = 1'b1; dig = 2'd2; end
         4'b1011: begin an_valid = 1'b1; dig = 2'd3; end
         default: begin an_valid = 1'b0; dig = 2'd0; end
      endcase
   end

   assign dig_hot = 4'b0001 << dig;

   ssd_seg_decode u_decode (
      .seg_i (seg_s_q),
      .hex_o (dec_hex),
      .ok_o  (dec_ok)
   );

   // FSM state and stability counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: count identical samples in SETTLE, park in HOLD after a capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (an_valid) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (!an_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!same) begin
               state_d = an_valid ? SETTLE : IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM output: the capture strobe fires on the edge that leaves SETTLE for HOLD.
   always_comb begin
      capture = (state_q == SETTLE) && an_valid && same && (cnt_q == CNT_LAST);
   end

`ifdef SSD_CAPTURE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt_q;
   logic          stall_q;

   assign to_hit = (to_cnt_q == TW'(TIMEOUT - 1));

   // Watchdog: count cycles since the last capture; saturate and flag a sticky stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q <= '0;
         stall_q  <= 1'b0;
      end else if (capture) begin
         to_cnt_q <= '0;
         stall_q  <= 1'b0;
      end else if (to_hit) begin
         stall_q  <= 1'b1;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign stall = stall_q;
`else
   assign to_hit = 1'b0;
   assign stall  = 1'b0;
`endif

   // Capture registers: update the selected digit, track seen digits, pulse on a full frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            seg_q[i] <= SEG_BLANK;
            hex_q[i] <= 4'd0;
         end
         ok_q   <= 4'b0000;
         seen_q <= 4'b0000;
         fv_q   <= 1'b0;
      end else begin
         fv_q <= 1'b0;
         if (capture) begin
            seg_q[dig] <= seg_s_q;
            hex_q[dig] <= dec_hex;
            ok_q[dig]  <= dec_ok;
            if ((seen_q | dig_hot) == 4'b1111) begin
               fv_q   <= 1'b1;
               seen_q <= 4'b0000;
            end else begin
               seen_q <= seen_q | dig_hot;
            end
         end else if (to_hit) begin
            seen_q <= 4'b0000;
         end
      end
   end

   assign seg0        = seg_q[0];
   assign seg1        = seg_q[1];
   assign seg2        = seg_q[2];
   assign seg3        = seg_q[3];
   assign hex0        = hex_q[0];
   assign hex1        = hex_q[1];
   assign hex2        = hex_q[2];
   assign hex3        = hex_q[3];
   assign dig_ok      = ok_q;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: self-checking bench for ssd_capture. A scoreboard queue holds
// expected captures (digit, pattern, decode, edge number); a negedge monitor pops
// them and compares every digit output, frame_valid and stall each cycle, while each
// scenario task adds its own direct checks. Define SSD_CAPTURE_TIMEOUT_EN to also
// cover the stall watchdog (TIMEOUT is shortened for the bench).
module tb_ssd_capture;

   localparam int STABLE_TB  = 8;
   localparam int TIMEOUT_TB = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a, b, c, d, e, f, g;
   logic an0, an1, an2, an3;
   logic [6:0] seg0, seg1, seg2, seg3;
   logic [3:0] hex0, hex1, hex2, hex3;
   logic [3:0] dig_ok;
   logic       frame_valid;
   logic       stall;

   ssd_capture #(.STABLE_CNT(STABLE_TB), .TIMEOUT(TIMEOUT_TB)) dut (
      .clk(clk), .reset(reset),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .an0(an0), .an1(an1), .an2(an2), .an3(an3),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
      .dig_ok(dig_ok), .frame_valid(frame_valid), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         dig;
      logic [6:0] seg;
      logic [3:0] hex;
      logic       ok;
      int         when;
   } exp_t;

   exp_t       q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic       rst_seen;
   int         fv_count = 0;
   logic [6:0] m_seg [4];
   logic [3:0] m_hex [4];
   logic [3:0] m_ok;
   logic [3:0] m_seen;
   logic       m_fv;
   logic       m_stall;
   int         last_evt = 0;

   function automatic logic [6:0] tb_glyph(input int v);
      case (v)
         0:  return 7'b0000001;  1:  return 7'b1001111;
         2:  return 7'b0010010;  3:  return 7'b0000110;
         4:  return 7'b1001100;  5:  return 7'b0100100;
         6:  return 7'b0100000;  7:  return 7'b0001111;
         8:  return 7'b0000000;  9:  return 7'b0000100;
         10: return 7'b0001000;  11: return 7'b1100000;
         12: return 7'b0110001;  13: return 7'b1000010;
         14: return 7'b0110000;  15: return 7'b0111000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Anode pattern {an3,an2,an1,an0} that selects a digit.
   function automatic logic [3:0] an_code(input int dig);
      case (dig)
         0: return 4'b0111;
         1: return 4'b1110;
         2: return 4'b1101;
         default: return 4'b1011;
      endcase
   endfunction

   // Edge counter and the reset value the DUT saw on that edge.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   // Scoreboard monitor: apply expected captures at their edge, then compare everything.
   always @(negedge clk) begin
      logic [6:0] o_seg [4];
      logic [3:0] o_hex [4];
      exp_t ent;
      if (cyc > 0) begin
         m_fv = 1'b0;
         if (rst_seen === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
               m_seg[i] = 7'b1111111;
               m_hex[i] = 4'd0;
            end
            m_ok = 4'b0; m_seen = 4'b0; m_stall = 1'b0;
            last_evt = cyc;
            q.delete();
         end else begin
            if (q.size() > 0 && q[0].when == cyc) begin
               ent = q.pop_front();
               m_seg[ent.dig] = ent.seg;
               m_hex[ent.dig] = ent.hex;
               m_ok[ent.dig]  = ent.ok;
               m_seen[ent.dig] = 1'b1;
               if (m_seen == 4'b1111) begin
                  m_fv = 1'b1;
                  m_seen = 4'b0;
               end
               m_stall = 1'b0;
               last_evt = cyc;
            end
`ifdef SSD_CAPTURE_TIMEOUT_EN
            else if (cyc - last_evt >= TIMEOUT_TB) begin
               m_stall = 1'b1;
               m_seen  = 4'b0;
            end
`endif
         end
         o_seg[0] = seg0; o_seg[1] = seg1; o_seg[2] = seg2; o_seg[3] = seg3;
         o_hex[0] = hex0; o_hex[1] = hex1; o_hex[2] = hex2; o_hex[3] = hex3;
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_seg[i] !== m_seg[i] || o_hex[i] !== m_hex[i] || dig_ok[i] !== m_ok[i]) begin
               n_fail++;
               $display("FAIL mon_digit%0d cyc=%0d got seg=%b hex=%h ok=%b want seg=%b hex=%h ok=%b",
                        i, cyc, o_seg[i], o_hex[i], dig_ok[i], m_seg[i], m_hex[i], m_ok[i]);
            end
         end
         n_tests++;
         if (frame_valid !== m_fv) begin
            n_fail++;
            $display("FAIL mon_frame_valid cyc=%0d got %b want %b", cyc, frame_valid, m_fv);
         end
         n_tests++;
         if (stall !== m_stall) begin
            n_fail++;
            $display("FAIL mon_stall cyc=%0d got %b want %b", cyc, stall, m_stall);
         end
         if (frame_valid === 1'b1) fv_count++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] s, input logic [3:0] an);
      {a, b, c, d, e, f, g} = s;
      {an3, an2, an1, an0}  = an;
   endtask

   task automatic push(input int dig, input logic [6:0] s, input logic [3:0] h,
                       input logic ok, input int when);
      exp_t ent;
      ent.dig = dig; ent.seg = s; ent.hex = h; ent.ok = ok; ent.when = when;
      q.push_back(ent);
   endtask

   // Show a legal glyph on a digit. Inputs change just after an edge; the next edge
   // samples them and the capture lands STABLE_CNT+1 edges after that sampling edge.
   task automatic show(input int dig, input int v, input int hold);
      drive(tb_glyph(v), an_code(dig));
      push(dig, tb_glyph(v), 4'(v), 1'b1, cyc + 1 + STABLE_TB + 1);
      step(hold);
   endtask

   task automatic test_reset();
      drive(7'b1111111, 4'b1111);
      reset = 1'b1;
      step(3);
      n_tests++;
      if ({seg0, seg1, seg2, seg3} !== {4{7'b1111111}} || {hex0, hex1, hex2, hex3} !== 16'h0 ||
          dig_ok !== 4'b0 || frame_valid !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values got seg=%b/%b/%b/%b hex=%h%h%h%h ok=%b fv=%b stall=%b want blank,0,0000,0,0",
                  seg0, seg1, seg2, seg3, hex3, hex2, hex1, hex0, dig_ok, frame_valid, stall);
      end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_single_capture();
      show(0, 2, 9);
      n_tests++;
      if (seg0 !== 7'b1111111) begin
         n_fail++;
         $display("FAIL latency_early got seg0=%b want 1111111", seg0);
      end
      step(1);
      n_tests++;
      if (seg0 !== 7'b0010010 || hex0 !== 4'd2 || dig_ok[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_capture got seg0=%b hex0=%h ok0=%b want 0010010 2 1", seg0, hex0, dig_ok[0]);
      end
      step(10);
   endtask

   task automatic test_scan_frame();
      int fv0;
      fv0 = fv_count;
      for (int i = 0; i < 4; i++) show(i, i + 1, 30);
      n_tests++;
      if ({hex3, hex2, hex1, hex0} !== 16'h4321) begin
         n_fail++;
         $display("FAIL scan_hex got %h%h%h%h want 4321", hex3, hex2, hex1, hex0);
      end
      n_tests++;
      if (fv_count - fv0 != 1) begin
         n_fail++;
         $display("FAIL scan_frame_pulses got %0d want 1", fv_count - fv0);
      end
   endtask

   task automatic test_toggle();
      for (int k = 0; k < 12; k++) begin
         drive((k % 2 == 1) ? 7'b1000000 : 7'b0000000, an_code(1));
         step(5);
      end
      n_tests++;
      if (seg1 !== tb_glyph(2) || hex1 !== 4'd2) begin
         n_fail++;
         $display("FAIL toggle_no_capture got seg1=%b hex1=%h want %b 2", seg1, hex1, tb_glyph(2));
      end
   endtask

   task automatic test_invalid_and_blank();
      drive(7'b0000000, 4'b1100);
      step(50);
      n_tests++;
      if (seg1 !== tb_glyph(2) || seg2 !== tb_glyph(3)) begin
         n_fail++;
         $display("FAIL two_anodes_no_capture got seg1=%b seg2=%b want %b %b",
                  seg1, seg2, tb_glyph(2), tb_glyph(3));
      end
      drive(7'b1111111, an_code(2));
      push(2, 7'b1111111, 4'd0, 1'b0, cyc + 1 + STABLE_TB + 1);
      step(20);
      n_tests++;
      if (seg2 !== 7'b1111111 || hex2 !== 4'd0 || dig_ok[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL blank_decode got seg2=%b hex2=%h ok2=%b want 1111111 0 0", seg2, hex2, dig_ok[2]);
      end
   endtask

   task automatic test_back_to_back();
      int fv0;
      fv0 = fv_count;
      show(3, 10, 12);
      show(3, 5, 12);
      n_tests++;
      if (hex3 !== 4'd5 || seg3 !== tb_glyph(5) || fv_count != fv0) begin
         n_fail++;
         $display("FAIL recapture_overwrite got hex3=%h seg3=%b pulses=%0d want 5 %b 0",
                  hex3, seg3, fv_count - fv0, tb_glyph(5));
      end
      show(0, 12, 12);
      show(1, 15, 12);
      n_tests++;
      if (hex1 !== 4'hF || hex0 !== 4'hC || fv_count - fv0 != 1) begin
         n_fail++;
         $display("FAIL second_frame got hex1=%h hex0=%h pulses=%0d want F C 1", hex1, hex0, fv_count - fv0);
      end
   endtask

`ifdef SSD_CAPTURE_TIMEOUT_EN
   task automatic test_timeout();
      int fv0;
      drive(7'b1111111, 4'b1111);
      step(TIMEOUT_TB + 12);
      n_tests++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_stall got %b want 1", stall);
      end
      fv0 = fv_count;
      show(2, 7, 14);
      n_tests++;
      if (stall !== 1'b0 || fv_count != fv0 || hex2 !== 4'd7) begin
         n_fail++;
         $display("FAIL stall_clear got stall=%b pulses=%0d hex2=%h want 0 0 7", stall, fv_count - fv0, hex2);
      end
   endtask
`endif

   task automatic test_reset_mid_settle();
      int n;
      drive(tb_glyph(9), an_code(2));
      n = cyc;
      step(4);
      reset = 1'b1;
      step(1);
      n_tests++;
      if ({seg0, seg1, seg2, seg3} !== {4{7'b1111111}} || {hex0, hex1, hex2, hex3} !== 16'h0 ||
          dig_ok !== 4'b0 || frame_valid !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_settle_reset got seg=%b/%b/%b/%b hex=%h%h%h%h ok=%b fv=%b stall=%b want reset values",
                  seg0, seg1, seg2, seg3, hex3, hex2, hex1, hex0, dig_ok, frame_valid, stall);
      end
      reset = 1'b0;
      step(1);
      push(2, tb_glyph(9), 4'd9, 1'b1, n + 5 + STABLE_TB + 1);
      step(7);
      n_tests++;
      if (seg2 !== 7'b1111111) begin
         n_fail++;
         $display("FAIL restart_early got seg2=%b want 1111111", seg2);
      end
      step(1);
      n_tests++;
      if (seg2 !== tb_glyph(9) || hex2 !== 4'd9 || dig_ok[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_capture got seg2=%b hex2=%h ok2=%b want %b 9 1", seg2, hex2, dig_ok[2], tb_glyph(9));
      end
   endtask

   initial begin
      drive(7'b1111111, 4'b1111);
      test_reset();
      test_single_capture();
      test_scan_frame();
      test_toggle();
      test_invalid_and_blank();
      test_back_to_back();
`ifdef SSD_CAPTURE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_settle();
      step(5);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
